// File: rtl/pos_entry_ctrl_if.sv
// Keypad sequencer bus: cursor/select inputs from the cursor controller and
// entry/total outputs toward the display and receipt logic.
interface pos_entry_ctrl_if #(
  parameter int DIGITS  = 6,
  parameter int TOTAL_W = 24
);
  logic [3:0]          cursor_x;
  logic [3:0]          cursor_y;
  logic                btn_sel;
  logic [4*DIGITS-1:0] entry_bcd;
  logic [7:0]          qty_bcd;
  logic [TOTAL_W-1:0]  total;
  logic [7:0]          item_cnt;
  logic [2:0]          state;
  logic                busy;
  logic                total_valid;
  logic                ovf;
  logic                err;

  modport master (
    output cursor_x, cursor_y, btn_sel,
    input  entry_bcd, qty_bcd, total, item_cnt, state, busy, total_valid, ovf, err
  );

  modport slave (
    input  cursor_x, cursor_y, btn_sel,
    output entry_bcd, qty_bcd, total, item_cnt, state, busy, total_valid, ovf, err
  );
endinterface

// File: rtl/pos_entry_ctrl.sv
// POS keypad entry sequencer: decodes the 4x4 grid key on each select press,
// builds a BCD price and quantity, and commits price*qty into a binary total.
module pos_entry_ctrl #(
  parameter int DIGITS  = 6,
  parameter int TOTAL_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  pos_entry_ctrl_if.slave  bus
);
  localparam int EW    = 4 * DIGITS;
  localparam int SUM_W = ((EW > TOTAL_W) ? EW : TOTAL_W) + 1;

  localparam logic [3:0] K_00  = 4'd10;
  localparam logic [3:0] K_CLR = 4'd11;
  localparam logic [3:0] K_DEL = 4'd12;
  localparam logic [3:0] K_ADD = 4'd13;
  localparam logic [3:0] K_QTY = 4'd14;
  localparam logic [3:0] K_ENT = 4'd15;

  typedef enum logic [2:0] {
    S_ENTRY = 3'd0, S_QTY = 3'd1, S_CONV = 3'd2, S_MUL = 3'd3, S_TOTAL = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               btn_d_q, btn_d_d;
  logic [EW-1:0]      entry_q, entry_d;
  logic [7:0]         qty_q, qty_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [7:0]         item_q, item_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [EW-1:0]      acc_q, acc_d;
  logic [7:0]         idx_q, idx_d;
  logic [6:0]         mul_q, mul_d;
  logic               to_total_q, to_total_d;

  logic               key_ok_s;
  logic [3:0]         key_s;
  logic [3:0]         dig_s;
  logic [SUM_W-1:0]   sum_s;
  logic               commit_ok_s;

  // Number of significant price digits (position of highest non-zero nibble).
  function automatic logic [7:0] digit_count(input logic [EW-1:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) n = 8'(i + 1);
      else n = n;
    end
    return n;
  endfunction

  function automatic logic [6:0] qty_to_bin(input logic [7:0] q);
    return 7'(q[7:4]) * 7'd10 + 7'(q[3:0]);
  endfunction

  // Key decode, current conversion digit and saturating-add operand.
  always_comb begin
    key_ok_s = ~bus.btn_sel & btn_d_q & (bus.cursor_x < 4'd4) & (bus.cursor_y < 4'd4);
    case ({bus.cursor_y[1:0], bus.cursor_x[1:0]})
      4'd0:    key_s = 4'd1;
      4'd1:    key_s = 4'd2;
      4'd2:    key_s = 4'd3;
      4'd3:    key_s = K_CLR;
      4'd4:    key_s = 4'd4;
      4'd5:    key_s = 4'd5;
      4'd6:    key_s = 4'd6;
      4'd7:    key_s = K_DEL;
      4'd8:    key_s = 4'd7;
      4'd9:    key_s = 4'd8;
      4'd10:   key_s = 4'd9;
      4'd11:   key_s = K_ADD;
      4'd12:   key_s = 4'd0;
      4'd13:   key_s = K_00;
      4'd14:   key_s = K_QTY;
      4'd15:   key_s = K_ENT;
      default: key_s = 4'd0;
    endcase
    dig_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == 8'(i)) dig_s = entry_q[4*i +: 4];
      else dig_s = dig_s;
    end
    sum_s       = SUM_W'(total_q) + SUM_W'(acc_q);
    commit_ok_s = (entry_q != '0) && !((state_q == S_QTY) && (qty_q == 8'd0));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    btn_d_d    = bus.btn_sel;
    entry_d    = entry_q;
    qty_d      = qty_q;
    total_d    = total_q;
    item_d     = item_q;
    ovf_d      = ovf_q;
    err_d      = 1'b0;
    acc_d      = acc_q;
    idx_d      = idx_q;
    mul_d      = mul_q;
    to_total_d = to_total_q;
    case (state_q)
      S_ENTRY, S_QTY: begin
        if (key_ok_s) begin
          case (key_s)
            K_CLR: begin
              entry_d = '0;
              qty_d   = 8'd0;
              state_d = S_ENTRY;
            end
            K_DEL: begin
              if (state_q == S_ENTRY) entry_d = {4'd0, entry_q[EW-1:4]};
              else qty_d = {4'd0, qty_q[7:4]};
            end
            K_QTY: begin
              if ((state_q == S_ENTRY) && (entry_q != '0)) begin
                state_d = S_QTY;
                qty_d   = 8'd0;
              end else begin
                err_d = 1'b1;
              end
            end
            K_ADD, K_ENT: begin
              if ((key_s == K_ENT) && (entry_q == '0)) begin
                state_d = S_TOTAL;
              end else if (commit_ok_s) begin
                state_d    = S_CONV;
                acc_d      = '0;
                idx_d      = 8'(DIGITS - 1);
                mul_d      = (state_q == S_QTY) ? qty_to_bin(qty_q) : 7'd1;
                to_total_d = (key_s == K_ENT);
              end else begin
                err_d = 1'b1;
              end
            end
            K_00: begin
              if (state_q != S_ENTRY) err_d = 1'b1;
              else if (entry_q == '0) entry_d = entry_q;
              else if (digit_count(entry_q) <= 8'(DIGITS - 2)) entry_d = {entry_q[EW-9:0], 8'h00};
              else err_d = 1'b1;
            end
            default: begin
              if (state_q == S_QTY) begin
                if (qty_q[7:4] == 4'd0) qty_d = {qty_q[3:0], key_s};
                else err_d = 1'b1;
              end else if ((entry_q == '0) && (key_s == 4'd0)) begin
                entry_d = entry_q;
              end else if (digit_count(entry_q) < 8'(DIGITS)) begin
                entry_d = {entry_q[EW-5:0], key_s};
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end else begin
          err_d = 1'b0;
        end
      end
      S_CONV: begin
        err_d = key_ok_s;
        acc_d = acc_q * EW'(4'd10) + EW'(dig_s);
        if (idx_q == 8'd0) state_d = S_MUL;
        else idx_d = idx_q - 8'd1;
      end
      S_MUL: begin
        err_d = key_ok_s;
        if (sum_s > SUM_W'({TOTAL_W{1'b1}})) begin
          total_d = {TOTAL_W{1'b1}};
          ovf_d   = 1'b1;
        end else begin
          total_d = sum_s[TOTAL_W-1:0];
        end
        mul_d = mul_q - 7'd1;
        // Last repeated add: retire the item and return to entry (or total view).
        if (mul_q == 7'd1) begin
          entry_d = '0;
          qty_d   = 8'd0;
          item_d  = (item_q != 8'hFF) ? item_q + 8'd1 : item_q;
          state_d = to_total_q ? S_TOTAL : S_ENTRY;
        end else begin
          state_d = S_MUL;
        end
      end
      S_TOTAL: begin
        if (key_ok_s && (key_s == K_CLR)) begin
          total_d = '0;
          item_d  = 8'd0;
          ovf_d   = 1'b0;
          state_d = S_ENTRY;
        end else begin
          state_d = S_TOTAL;
        end
      end
      default: state_d = S_ENTRY;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ENTRY;
      btn_d_q    <= 1'b1;
      entry_q    <= '0;
      qty_q      <= 8'd0;
      total_q    <= '0;
      item_q     <= 8'd0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      idx_q      <= 8'd0;
      mul_q      <= 7'd0;
      to_total_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_d_q    <= btn_d_d;
      entry_q    <= entry_d;
      qty_q      <= qty_d;
      total_q    <= total_d;
      item_q     <= item_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      mul_q      <= mul_d;
      to_total_q <= to_total_d;
    end
  end

  assign bus.entry_bcd   = entry_q;
  assign bus.qty_bcd     = qty_q;
  assign bus.total       = total_q;
  assign bus.item_cnt    = item_q;
  assign bus.state       = state_q;
  assign bus.busy        = (state_q == S_CONV) || (state_q == S_MUL);
  assign bus.total_valid = (state_q == S_TOTAL);
  assign bus.ovf         = ovf_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_pos_entry_ctrl.sv
// Directed bench for pos_entry_ctrl: a 24-bit-total instance for the main
// flows and an 8-bit-total instance for saturation.
module tb_pos_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int busy_cnt = 0, err_cnt = 0, busy8_cnt = 0, err8_cnt = 0;
  int b0, e0;

  localparam logic [3:0] K_00 = 4'd10, K_CLR = 4'd11, K_DEL = 4'd12;
  localparam logic [3:0] K_ADD = 4'd13, K_QTY = 4'd14, K_ENT = 4'd15;

  pos_entry_ctrl_if #(.DIGITS(6), .TOTAL_W(24)) ifa ();
  pos_entry_ctrl_if #(.DIGITS(6), .TOTAL_W(8))  ifb ();

  pos_entry_ctrl #(.DIGITS(6), .TOTAL_W(24)) dut  (.clk(clk), .rst(rst), .bus(ifa));
  pos_entry_ctrl #(.DIGITS(6), .TOTAL_W(8))  dut8 (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.busy) busy_cnt++;
    if (ifa.err)  err_cnt++;
    if (ifb.busy) busy8_cnt++;
    if (ifb.err)  err8_cnt++;
  end

  task automatic press_xy(input logic [3:0] x, input logic [3:0] y, input bit w);
    @(negedge clk);
    if (w) begin
      ifb.cursor_x = x; ifb.cursor_y = y; ifb.btn_sel = 1'b0;
    end else begin
      ifa.cursor_x = x; ifa.cursor_y = y; ifa.btn_sel = 1'b0;
    end
    @(negedge clk);
    ifa.btn_sel = 1'b1;
    ifb.btn_sel = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k, input bit w);
    logic [3:0] x, y;
    case (k)
      4'd0:  begin x = 4'd0; y = 4'd3; end
      K_00:  begin x = 4'd1; y = 4'd3; end
      K_QTY: begin x = 4'd2; y = 4'd3; end
      K_ENT: begin x = 4'd3; y = 4'd3; end
      K_CLR: begin x = 4'd3; y = 4'd0; end
      K_DEL: begin x = 4'd3; y = 4'd1; end
      K_ADD: begin x = 4'd3; y = 4'd2; end
      default: begin x = 4'((k - 4'd1) % 4'd3); y = 4'((k - 4'd1) / 4'd3); end
    endcase
    press_xy(x, y, w);
  endtask

  task automatic wait_idle(input bit w);
    int n = 0;
    while ((w ? ifb.busy : ifa.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", 1'b1, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ifa.entry_bcd, ifa.qty_bcd, ifa.total, ifa.item_cnt, ifa.state, ifa.busy,
         ifa.total_valid, ifa.ovf, ifa.err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: entry=%h qty=%h total=%0d state=%0d, required all 0",
               ifa.entry_bcd, ifa.qty_bcd, ifa.total, ifa.state);
    end
  endtask

  task automatic test_single_add();
    press(4'd1, 0); press(4'd2, 0); press(4'd5, 0);
    checks++;
    if (ifa.entry_bcd !== 24'h000125) begin
      failures++; $display("FAIL entry_125: got %h required 000125", ifa.entry_bcd);
    end
    b0 = busy_cnt;
    press(K_ADD, 0);
    wait_idle(0);
    checks++;
    if (busy_cnt - b0 !== 7) begin
      failures++; $display("FAIL busy_len_7: got %0d required 7", busy_cnt - b0);
    end
    checks++;
    if (ifa.total !== 24'd125) begin
      failures++; $display("FAIL total_125: got %0d required 125", ifa.total);
    end
    checks++;
    if ({ifa.item_cnt, ifa.state, ifa.entry_bcd} !== {8'd1, 3'd0, 24'h0}) begin
      failures++;
      $display("FAIL post_add: item=%0d state=%0d entry=%h required 1 0 0",
               ifa.item_cnt, ifa.state, ifa.entry_bcd);
    end
  endtask

  task automatic test_qty_add();
    press(4'd2, 0); press(4'd5, 0); press(4'd0, 0); press(K_QTY, 0);
    checks++;
    if (ifa.state !== 3'd1) begin
      failures++; $display("FAIL qty_state: got %0d required 1", ifa.state);
    end
    press(4'd3, 0);
    checks++;
    if (ifa.qty_bcd !== 8'h03) begin
      failures++; $display("FAIL qty_bcd: got %h required 03", ifa.qty_bcd);
    end
    b0 = busy_cnt;
    press(K_ADD, 0);
    wait_idle(0);
    checks++;
    if (busy_cnt - b0 !== 9) begin
      failures++; $display("FAIL busy_len_9: got %0d required 9", busy_cnt - b0);
    end
    checks++;
    if ({ifa.total, ifa.item_cnt} !== {24'd875, 8'd2}) begin
      failures++; $display("FAIL total_875: total=%0d item=%0d required 875 2", ifa.total, ifa.item_cnt);
    end
    e0 = err_cnt;
    press(K_QTY, 0); press(4'd0, 0); press(K_ADD, 0);
    checks++;
    if ({err_cnt - e0, ifa.total, ifa.state} !== {32'd2, 24'd875, 3'd0}) begin
      failures++;
      $display("FAIL empty_add: errs=%0d total=%0d state=%0d required 2 875 0",
               err_cnt - e0, ifa.total, ifa.state);
    end
  endtask

  task automatic test_digit_limits();
    press(4'd0, 0); press(4'd0, 0); press(4'd7, 0); press(K_00, 0);
    press(4'd9, 0); press(4'd9, 0); press(4'd9, 0);
    checks++;
    if (ifa.entry_bcd !== 24'h700999) begin
      failures++; $display("FAIL entry_full: got %h required 700999", ifa.entry_bcd);
    end
    e0 = err_cnt;
    press(4'd9, 0);
    checks++;
    if ({err_cnt - e0, ifa.entry_bcd} !== {32'd1, 24'h700999}) begin
      failures++; $display("FAIL digit_overflow: errs=%0d entry=%h required 1 700999", err_cnt - e0, ifa.entry_bcd);
    end
    press(K_DEL, 0);
    checks++;
    if (ifa.entry_bcd !== 24'h070099) begin
      failures++; $display("FAIL del: got %h required 070099", ifa.entry_bcd);
    end
    e0 = err_cnt;
    press(K_00, 0);
    checks++;
    if ({err_cnt - e0, ifa.entry_bcd} !== {32'd1, 24'h070099}) begin
      failures++; $display("FAIL dbl_zero_limit: errs=%0d entry=%h required 1 070099", err_cnt - e0, ifa.entry_bcd);
    end
    press(K_CLR, 0);
    checks++;
    if (ifa.entry_bcd !== 24'h0) begin
      failures++; $display("FAIL clr_entry: got %h required 000000", ifa.entry_bcd);
    end
  endtask

  task automatic test_ent_total();
    do_reset();
    press(4'd5, 0);
    press(K_ENT, 0);
    wait_idle(0);
    checks++;
    if ({ifa.total, ifa.total_valid, ifa.state, ifa.item_cnt} !== {24'd5, 1'b1, 3'd4, 8'd1}) begin
      failures++;
      $display("FAIL ent_total: total=%0d valid=%0b state=%0d item=%0d required 5 1 4 1",
               ifa.total, ifa.total_valid, ifa.state, ifa.item_cnt);
    end
    e0 = err_cnt;
    press(4'd3, 0);
    checks++;
    if ({err_cnt - e0, ifa.state, ifa.entry_bcd, ifa.total} !== {32'd0, 3'd4, 24'h0, 24'd5}) begin
      failures++;
      $display("FAIL total_ignore: errs=%0d state=%0d entry=%h total=%0d required 0 4 0 5",
               err_cnt - e0, ifa.state, ifa.entry_bcd, ifa.total);
    end
    press(K_CLR, 0);
    checks++;
    if ({ifa.total, ifa.state, ifa.total_valid, ifa.item_cnt} !== {24'd0, 3'd0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL total_clr: total=%0d state=%0d valid=%0b item=%0d required 0 0 0 0",
               ifa.total, ifa.state, ifa.total_valid, ifa.item_cnt);
    end
  endtask

  task automatic test_saturation();
    press(4'd2, 1); press(4'd0, 1); press(4'd0, 1); press(K_ADD, 1);
    wait_idle(1);
    checks++;
    if ({ifb.total, ifb.ovf} !== {8'd200, 1'b0}) begin
      failures++; $display("FAIL sat_first: total=%0d ovf=%0b required 200 0", ifb.total, ifb.ovf);
    end
    press(4'd1, 1); press(4'd0, 1); press(4'd0, 1); press(K_QTY, 1); press(4'd3, 1);
    b0 = busy8_cnt;
    e0 = err8_cnt;
    press(K_ADD, 1);
    repeat (4) @(negedge clk);
    press(4'd4, 1);
    checks++;
    if (err8_cnt - e0 !== 1) begin
      failures++; $display("FAIL busy_press_err: errs=%0d required 1", err8_cnt - e0);
    end
    wait_idle(1);
    checks++;
    if ({ifb.total, ifb.ovf, ifb.item_cnt, ifb.entry_bcd} !== {8'd255, 1'b1, 8'd2, 24'h0}) begin
      failures++;
      $display("FAIL sat_total: total=%0d ovf=%0b item=%0d entry=%h required 255 1 2 0",
               ifb.total, ifb.ovf, ifb.item_cnt, ifb.entry_bcd);
    end
    checks++;
    if (busy8_cnt - b0 !== 9) begin
      failures++; $display("FAIL sat_busy_len: got %0d required 9", busy8_cnt - b0);
    end
    press(K_ENT, 1); press(K_CLR, 1);
    checks++;
    if ({ifb.total, ifb.ovf, ifb.state} !== {8'd0, 1'b0, 3'd0}) begin
      failures++; $display("FAIL ovf_clear: total=%0d ovf=%0b state=%0d required 0 0 0", ifb.total, ifb.ovf, ifb.state);
    end
  endtask

  task automatic test_reset_mid_and_range();
    press(4'd1, 0); press(4'd2, 0); press(K_QTY, 0); press(4'd5, 0); press(K_ADD, 0);
    repeat (6) @(negedge clk);
    checks++;
    if (ifa.state !== 3'd3) begin
      failures++; $display("FAIL mid_mul_state: got %0d required 3", ifa.state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ifa.entry_bcd, ifa.qty_bcd, ifa.total, ifa.item_cnt, ifa.state, ifa.busy,
         ifa.total_valid, ifa.ovf, ifa.err} !== '0) begin
      failures++;
      $display("FAIL mid_reset: entry=%h qty=%h total=%0d state=%0d busy=%0b required all 0",
               ifa.entry_bcd, ifa.qty_bcd, ifa.total, ifa.state, ifa.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.total, ifa.state, ifa.busy} !== {24'd0, 3'd0, 1'b0}) begin
      failures++; $display("FAIL post_reset: total=%0d state=%0d busy=%0b required 0 0 0", ifa.total, ifa.state, ifa.busy);
    end
    press(4'd7, 0);
    e0 = err_cnt;
    press_xy(4'd4, 4'd0, 0);
    press_xy(4'd0, 4'd4, 0);
    checks++;
    if ({err_cnt - e0, ifa.entry_bcd, ifa.state} !== {32'd0, 24'h000007, 3'd0}) begin
      failures++;
      $display("FAIL out_of_range: errs=%0d entry=%h state=%0d required 0 000007 0",
               err_cnt - e0, ifa.entry_bcd, ifa.state);
    end
  endtask

  initial begin
    ifa.cursor_x = 4'd0; ifa.cursor_y = 4'd0; ifa.btn_sel = 1'b1;
    ifb.cursor_x = 4'd0; ifb.cursor_y = 4'd0; ifb.btn_sel = 1'b1;
    test_reset();
    test_single_add();
    test_qty_add();
    test_digit_limits();
    test_ent_total();
    test_saturation();
    test_reset_mid_and_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pos_entry_ctrl.md
Name: pos_entry_ctrl

Overview:
- Keypad-entry sequencer for the POS 4x4 on-screen keypad.
- Decodes the grid cell under the cursor when the select button is pressed, accumulates a BCD price and a quantity, and commits price*qty into a running binary total.
- Commit uses a multi-cycle BCD-to-binary conversion followed by a repeated-add multiply.
- Sits between the cursor controller and the display/receipt logic.

Parameters:
DIGITS, 6, max price digits held in entry_bcd
TOTAL_W, 24, running-total width in bits

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
cursor_x  in  4  cursor column, 0..3 valid
cursor_y  in  4  cursor row, 0..3 valid
btn_sel  in  1  select button, active-low
entry_bcd  out  4*DIGITS  price digits, LSD in [3:0]
qty_bcd  out  8  quantity digits, LSD in [3:0]
total  out  TOTAL_W  running total, binary
item_cnt  out  8  committed item count, saturates at 255
state  out  3  FSM state code
busy  out  1  high in CONV and MUL
total_valid  out  1  high in TOTAL
ovf  out  1  sticky total saturation flag
err  out  1  one-cycle pulse on rejected key

Behaviour:
- Reset values: all outputs 0. The internal btn_sel delay register resets to 1. FSM resets to ENTRY.
- Press detection:
  - sel_pulse = ~btn_sel & btn_sel_d, one cycle per press.
  - The key is decoded from cursor_x/cursor_y in the sel_pulse cycle.
  - A press with cursor_x>3 or cursor_y>3 is ignored with no err.
- Key map, row y then columns x0..x3:
  - y0: 1, 2, 3, CLR
  - y1: 4, 5, 6, DEL
  - y2: 7, 8, 9, ADD
  - y3: 0, 00, QTY, ENT
- States and codes: ENTRY=0, QTY=1, CONV=2, MUL=3, TOTAL=4.
- ENTRY, digit key d:
  - If entry_bcd==0 and d==0: no-op.
  - Else if digit count < DIGITS: shift entry_bcd left 4 and insert d.
  - Else: err.
- ENTRY, 00 key:
  - If entry_bcd==0: no-op.
  - Else if count <= DIGITS-2: shift left 8.
  - Else: err.
- ENTRY, DEL: shift entry_bcd right 4, zero fill.
- QTY key:
  - In ENTRY with entry_bcd!=0: go to QTY with qty_bcd=0.
  - Otherwise: err.
- QTY, digit key:
  - Accepted while qty has <2 digits; shifts into qty_bcd.
  - A third digit gives err.
  - DEL shifts qty_bcd right 4.
  - 00 key gives err.
- CLR in ENTRY or QTY: entry_bcd=0, qty_bcd=0, go to ENTRY.
- ADD in ENTRY or QTY:
  - If entry_bcd==0, or a QTY state with qty_bcd==0: err, no state change.
  - Else go to CONV. An effective qty of 1 is used when the QTY state was never entered.
- CONV: DIGITS cycles. Each cycle does acc = acc*10 + digit, MSB digit first.
- MUL: qty cycles. Each cycle does total += acc.
  - On overflow, total saturates at 2^TOTAL_W-1 and ovf is set.
  - On MUL exit: entry_bcd=0, qty_bcd=0, item_cnt+1, go to ENTRY.
- busy timing:
  - busy is high for exactly DIGITS+qty cycles.
  - It rises the cycle after the ADD sel_pulse.
  - total holds its final value when busy falls.
- ENT in ENTRY or QTY:
  - If entry_bcd!=0: perform the ADD sequence, then go to TOTAL instead of ENTRY.
  - Else: go to TOTAL directly.
- TOTAL:
  - total_valid=1.
  - CLR sets total=0, item_cnt=0, ovf=0 and goes to ENTRY.
  - All other keys are ignored with no err.
- Any sel_pulse during CONV or MUL: err, key discarded.
- Priority: there is one key per cycle by construction, so there are no simultaneous-key cases.
- Reset mid-operation: rst at any point, including CONV or MUL, returns every register to its reset value immediately.

Test Plan:
1. Keys 1, 2, 5, ADD -> entry_bcd=0x000125 before ADD; busy high for 7 cycles; total=125; item_cnt=1; state=ENTRY.
2. Keys 2, 5, 0, QTY, 3, ADD -> busy high for 9 cycles; total increases by 750. Then QTY, 0, ADD with entry 0 -> err pulse, total unchanged.
3. Keys 0, 0, 7, 00, 9, 9, 9, 9 -> entry_bcd=0x700999 after the 7th digit; the final 9 gives err. DEL -> 0x070099.
4. Key 5 then ENT -> total=5 and total_valid=1. Key 3 in TOTAL is ignored. CLR -> total=0, state=ENTRY.
5. TOTAL_W=8: commit 200 then 100 -> total=255, ovf=1. A press during MUL -> err, and total is still correct.
6. Assert rst during MUL, or set the cursor to (4,0) and press -> all outputs are 0 after rst; the out-of-range press produces no change and no err.
